// File: rtl/md5_candidate_gen.sv
// md5_candidate_gen
//   Enumerates every fixed-length string over [CHAR_LO..CHAR_HI] as an odometer and
//   presents each one as a right-aligned message for an MD5 core. After the last
//   candidate (or an abort), it waits out the core pipeline (DRAIN) before flagging DONE.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : begin enumeration (sampled in IDLE/DONE)
//   stop       : abort enumeration (sampled in RUN)
//   cfg_len    : candidate length in characters, sampled with start
//   message    : candidate, character k at [8k+7:8k], zero above 8*len
//   length     : candidate length in bits
//   msg_valid  : message/length carry a new candidate this cycle
//   tag_valid  : msg_valid delayed LATENCY cycles (aligned with the hash output)
//   cand_count : candidates emitted since the last accepted start (saturating)
//   busy       : RUN or DRAIN
//   done       : DONE
//   cfg_err    : one-cycle pulse on a rejected start
`timescale 1ns/1ps
module md5_candidate_gen #(
    parameter int         MAX_LEN = 8,
    parameter logic [7:0] CHAR_LO = 8'h61,
    parameter logic [7:0] CHAR_HI = 8'h7A,
    parameter int         LATENCY = 66
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic [5:0]   cfg_len,
    output logic [447:0] message,
    output logic [63:0]  length,
    output logic         msg_valid,
    output logic         tag_valid,
    output logic [63:0]  cand_count,
    output logic         busy,
    output logic         done,
    output logic         cfg_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [15:0] DRAIN_LAST = 16'(LATENCY - 1);

    logic [1:0]         r_state;
    logic [5:0]         r_len;
    logic [447:0]       r_message;
    logic [63:0]        r_length;
    logic               r_msg_valid;
    logic [LATENCY-1:0] r_tag_sr;
    logic [63:0]        r_count;
    logic               r_busy;
    logic               r_done;
    logic               r_cfg_err;
    logic [15:0]        r_drain;

    logic [1:0]         w_state_d;
    logic               w_idle_or_done;
    logic               w_cfg_ok;
    logic               w_start_ok;
    logic [447:0]       w_load_msg;
    logic [447:0]       w_next_msg;
    logic               w_all_hi;
    logic               w_carry;
    logic [LATENCY-1:0] w_tag_next;

    assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_cfg_ok       = (cfg_len != 6'd0) && (int'(cfg_len) <= MAX_LEN);
    assign w_start_ok     = start && w_idle_or_done && w_cfg_ok;

    // Shift in at the bottom; the top bit is the tag output.
    assign w_tag_next = LATENCY'({r_tag_sr, r_msg_valid});

    // First candidate: all active positions at CHAR_LO.
    always_comb begin
        w_load_msg = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (k < int'(cfg_len)) begin
                w_load_msg[8*k +: 8] = CHAR_LO;
            end
        end
    end

    // Odometer step over the active positions; w_all_hi marks the terminal candidate.
    always_comb begin
        w_next_msg = '0;
        w_all_hi   = 1'b1;
        w_carry    = 1'b1;
        for (int k = 0; k < MAX_LEN; k++) begin
            if (k < int'(r_len)) begin
                if (r_message[8*k +: 8] != CHAR_HI) begin
                    w_all_hi = 1'b0;
                end
                if (w_carry) begin
                    if (r_message[8*k +: 8] == CHAR_HI) begin
                        w_next_msg[8*k +: 8] = CHAR_LO;
                    end else begin
                        w_next_msg[8*k +: 8] = r_message[8*k +: 8] + 8'd1;
                        w_carry              = 1'b0;
                    end
                end else begin
                    w_next_msg[8*k +: 8] = r_message[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (w_start_ok) w_state_d = ST_RUN;
            ST_RUN:           if (w_all_hi || stop) w_state_d = ST_DRAIN;
            ST_DRAIN:         if (r_drain == DRAIN_LAST) w_state_d = ST_DONE;
            default:          w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_message   <= '0;
            r_length    <= '0;
            r_msg_valid <= 1'b0;
            r_tag_sr    <= '0;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_drain     <= '0;
        end else begin
            r_state     <= w_state_d;
            r_busy      <= (w_state_d == ST_RUN) || (w_state_d == ST_DRAIN);
            r_done      <= (w_state_d == ST_DONE);
            r_cfg_err   <= start && w_idle_or_done && !w_cfg_ok;
            r_tag_sr    <= w_tag_next;
            r_msg_valid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_len       <= cfg_len;
                        r_message   <= w_load_msg;
                        r_length    <= {55'd0, cfg_len, 3'd0};
                        r_msg_valid <= 1'b1;
                        r_count     <= 64'd1;
                        r_drain     <= '0;
                    end
                end
                ST_RUN: begin
                    // Terminal candidate takes priority over stop; both end in DRAIN.
                    if (!w_all_hi && !stop) begin
                        r_message   <= w_next_msg;
                        r_msg_valid <= 1'b1;
                        if (r_count != '1) begin
                            r_count <= r_count + 64'd1;
                        end
                    end else begin
                        r_drain <= '0;
                    end
                end
                ST_DRAIN: r_drain <= r_drain + 16'd1;
                default: ;
            endcase
        end
    end

    assign message    = r_message;
    assign length     = r_length;
    assign msg_valid  = r_msg_valid;
    assign tag_valid  = r_tag_sr[LATENCY-1];
    assign cand_count = r_count;
    assign busy       = r_busy;
    assign done       = r_done;
    assign cfg_err    = r_cfg_err;

endmodule
